io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//   Conditions raw board inputs (switches/keys) before they reach core.io_input_bus.
//   Per bit: synchroniser chain, debounce filter, sticky rising-edge flag.
//   Debounced levels drive io_input_bus; edge flags let software poll key presses.
//   Sits directly upstream of core, in the same clock domain.
// PARAMETERS
//   WIDTH            14  number of input bits; matches the width of core io_input_bus
//   SYNC_STAGES      2   synchroniser flops per bit; must be >= 2
//   DEBOUNCE_CYCLES  4   consecutive mismatching cycles before a level is accepted; >= 1
//                        (simulation default; board builds override, e.g. 500000 at 50 MHz)
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  width of the debounce counter (derived)
// PORTS
//   clock          in   1      system clock, rising edge
//   reset          in   1      synchronous, active-high
//   raw_in         in   WIDTH  asynchronous pad inputs
//   io_input_bus   out  WIDTH  debounced levels, to core.io_input_bus
//   rise_pending   out  WIDTH  sticky flag per bit: debounced 0->1 seen
//   clear_valid    in   1      clear strobe, qualifies clear_mask
//   clear_mask     in   WIDTH  bits of rise_pending to clear when clear_valid=1
//   any_pending    out  1      |rise_pending, registered view (combinational OR of flops)
// BEHAVIOUR
//   Reset: sync chain, stable levels, counters and rise_pending all 0.
//     io_input_bus=0, any_pending=0 on the edge after reset is sampled high.
//     Reset mid-debounce discards any partial count. No flag is set by reset.
//   Synchroniser: raw_in passes through SYNC_STAGES flops -> sync_out.
//   Debounce, per bit, each edge:
//     sync_out == stable             -> cnt <= 0
//     mismatch, cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//     mismatch, cnt == DEBOUNCE_CYCLES-1 -> stable <= sync_out; cnt <= 0
//   Any return to agreement before acceptance resets cnt. Glitches shorter than
//     DEBOUNCE_CYCLES cycles (after sync) never reach io_input_bus.
//   Latency: for a clean step, edge 1 is the first edge that samples the new raw value.
//     io_input_bus changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
//   io_input_bus = stable, driven directly from flops.
//   Edge flags:
//     rise_pending[i] sets on the same edge that stable[i] goes 0->1.
//     It holds until cleared: clear_valid && clear_mask[i].
//     Set and clear on the same edge -> set wins (flag stays 1).
//     Falling transitions never set a flag.
//     clear_mask is ignored when clear_valid=0.
//   All bits are independent; simultaneous events on different bits need no ordering.
//   Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 via the acceptance rule.
// STRUCTURE
//   Shared header io_defs.vh: IO_IN_W=14, IO_OUT_W=52, DEFAULT_DEBOUNCE_CYCLES,
//     DEFAULT_SYNC_STAGES; core and this block both use IO_IN_W.
//   Sub-module io_debounce_bit: one bit of sync chain + counter + stable + rise pulse.
//     Instantiated WIDTH times with a generate loop.
//   Top holds the rise_pending register, clear logic and the any_pending OR.
// TESTING (defaults WIDTH=14, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. Power-up: reset=1 for 3 edges with raw_in=14'h3FFF.
//      -> io_input_bus=0, rise_pending=0 throughout reset.
//      After release: io_input_bus=14'h3FFF on the 6th edge; rise_pending=14'h3FFF;
//      any_pending=1.
//   2. Glitch: raw_in[0] high for 3 cycles, then low.
//      -> io_input_bus[0] stays 0; rise_pending[0] stays 0.
//   3. Clean step: raw_in[5] 0->1.
//      -> io_input_bus[5]=1 and rise_pending[5]=1 on exactly edge 6.
//      Step back 1->0 -> io_input_bus[5]=0 on edge 6; flag unchanged.
//   4. Clear/set race: rise_pending=14'h0021.
//      clear_valid=1 with clear_mask=14'h0021, on the same edge as a new bit-5 rise.
//      -> rise_pending=14'h0020.
//      Then clear_valid=0 with mask=14'h3FFF -> no change.
//   5. Bounce: raw_in[3] toggles every 2 cycles for 12 cycles, then holds 1.
//      -> exactly one 0->1 on io_input_bus[3], 6 edges after the final toggle.
//      -> rise_pending[3] set once.
//   6. Reset mid-debounce: raw_in[7] rises; reset=1 on edge 4; release with raw_in[7]=1.
//      -> io_input_bus[7]=0 during reset; goes 1 on edge 6 after release
//      (full restart, no carried count).

Source files
------------

// File: rtl/io_input_conditioner_pkg.sv
// Shared I/O constants and debounce helper types for the input conditioner.
// The core uses IO_IN_W, so both blocks agree on the input bus width.
package io_input_conditioner_pkg;

  localparam int IO_IN_W                 = 14;
  localparam int IO_OUT_W                = 52;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // What the debounce counter does on the next edge for one bit.
  typedef enum logic [1:0] {
    DB_AGREE  = 2'd0,
    DB_COUNT  = 2'd1,
    DB_ACCEPT = 2'd2
  } db_action_e;

  function automatic db_action_e db_action(input logic match, input logic at_last);
    if (match)        return DB_AGREE;
    else if (at_last) return DB_ACCEPT;
    else              return DB_COUNT;
  endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// Pad-side and core-side signals of the input conditioner.
// The master modport is the conditioner itself; slave is its user.
interface io_input_conditioner_if
  import io_input_conditioner_pkg::*;
#(
  parameter int WIDTH = IO_IN_W
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] io_input_bus;
  logic [WIDTH-1:0] rise_pending;
  logic             clear_valid;
  logic [WIDTH-1:0] clear_mask;
  logic             any_pending;

  modport master (
    input  raw_in,
    input  clear_valid,
    input  clear_mask,
    output io_input_bus,
    output rise_pending,
    output any_pending
  );

  modport slave (
    output raw_in,
    output clear_valid,
    output clear_mask,
    input  io_input_bus,
    input  rise_pending,
    input  any_pending
  );

endinterface

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter, accepted level and
// a single-cycle pulse marking the edge on which the level goes 0->1.
module io_debounce_bit
  import io_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   sync_out;
  db_action_e             action;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    action = db_action(sync_out == stable_q, cnt_q == CNT_LAST);
    rise   = (action == DB_ACCEPT) && sync_out;
  end

  // NOTE: state updates use non-blocking assignments so every flop in the
  // chain samples its pre-edge neighbour; blocking would collapse the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      case (action)
        DB_AGREE:  cnt_q <= '0;
        DB_COUNT:  cnt_q <= cnt_q + CNT_W'(1);
        DB_ACCEPT: begin
          stable_q <= sync_out;
          cnt_q    <= '0;
        end
        default:   cnt_q <= '0;
      endcase
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw board inputs: per-bit sync + debounce, plus sticky
// rising-edge flags that software clears with a masked strobe.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = IO_IN_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  io_input_conditioner_if.master cond
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] rise_pending_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .raw  (cond.raw_in[i]),
      .level(stable[i]),
      .rise (rise[i])
    );
  end

  // NOTE: a combinational block assigns its output on every path, so the
  // mask gating infers a mux and never a latch.
  always_comb begin
    clear_bits = cond.clear_valid ? cond.clear_mask : '0;
  end

  // A rise on the same edge as its clear wins: the OR is applied last.
  always_ff @(posedge clock) begin
    if (reset) rise_pending_q <= '0;
    else       rise_pending_q <= (rise_pending_q & ~clear_bits) | rise;
  end

  assign cond.io_input_bus = stable;
  assign cond.rise_pending = rise_pending_q;
  assign cond.any_pending  = |rise_pending_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner: directed scenarios plus a
// randomized run compared against a window-based behavioural model.
module tb_io_input_conditioner;
  import io_input_conditioner_pkg::*;

  localparam int W = IO_IN_W;
  localparam int S = DEFAULT_SYNC_STAGES;
  localparam int D = DEFAULT_DEBOUNCE_CYCLES;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  io_input_conditioner_if #(.WIDTH(W)) bus_if ();

  io_input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cond (bus_if.master)
  );

  int checks = 0;
  int errors = 0;

  // Model: raw delay line of S samples, a window of the last D synchronised
  // values, and the edge of each bit's last change (or reset).
  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_rp;
  int           m_last [W];
  int           m_edge = 0;

  task automatic model_edge();
    logic [W-1:0] sb, rises, clr;
    bit all_diff;
    m_edge++;
    if (reset) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      m_hist.delete();
      m_stable = '0;
      m_rp     = '0;
      for (int i = 0; i < W; i++) m_last[i] = m_edge;
    end else begin
      sb = m_pipe[S-1];
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = bus_if.raw_in;
      m_hist.push_back(sb);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      rises = '0;
      for (int i = 0; i < W; i++) begin
        if ((m_edge - m_last[i]) >= D && m_hist.size() == D) begin
          all_diff = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            m_last[i]   = m_edge;
            rises[i]    = m_stable[i];
          end
        end
      end
      clr  = bus_if.clear_valid ? bus_if.clear_mask : '0;
      m_rp = (m_rp & ~clr) | rises;
    end
  endtask

  // Inputs only change at the falling edge; outputs are read there too.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_bus;
    bus_if.raw_in      = 14'h3FFF;
    bus_if.clear_valid = 1'b0;
    bus_if.clear_mask  = '0;
    reset = 1'b1;
    for (int e = 0; e < 3; e++) begin
      cycle();
      checks++;
      if (bus_if.io_input_bus !== '0 || bus_if.rise_pending !== '0) begin
        errors++;
        $display("FAIL reset_hold bus=%h rp=%h want 0000/0000", bus_if.io_input_bus, bus_if.rise_pending);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      exp_bus = (e >= 6) ? 14'h3FFF : 14'h0000;
      checks++;
      if (bus_if.io_input_bus !== exp_bus) begin
        errors++;
        $display("FAIL powerup_edge%0d bus=%h want %h", e, bus_if.io_input_bus, exp_bus);
      end
    end
    checks++;
    if (bus_if.rise_pending !== 14'h3FFF || bus_if.any_pending !== 1'b1) begin
      errors++;
      $display("FAIL powerup_flags rp=%h any=%b want 3fff/1", bus_if.rise_pending, bus_if.any_pending);
    end
  endtask

  task automatic test_glitch();
    bus_if.raw_in      = '0;
    bus_if.clear_valid = 1'b1;
    bus_if.clear_mask  = 14'h3FFF;
    for (int e = 0; e < 10; e++) cycle();
    bus_if.clear_valid = 1'b0;
    checks++;
    if (bus_if.io_input_bus !== '0 || bus_if.rise_pending !== '0 || bus_if.any_pending !== 1'b0) begin
      errors++;
      $display("FAIL glitch_setup bus=%h rp=%h any=%b want 0/0/0", bus_if.io_input_bus, bus_if.rise_pending, bus_if.any_pending);
    end
    for (int e = 0; e < 13; e++) begin
      bus_if.raw_in[0] = (e < 3);
      cycle();
      checks++;
      if (bus_if.io_input_bus[0] !== 1'b0 || bus_if.rise_pending[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_edge%0d bus0=%b rp0=%b want 0/0", e, bus_if.io_input_bus[0], bus_if.rise_pending[0]);
      end
    end
  endtask

  task automatic test_step();
    bus_if.raw_in[5] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      checks++;
      if (bus_if.io_input_bus[5] !== (e >= 6) || bus_if.rise_pending[5] !== (e >= 6)) begin
        errors++;
        $display("FAIL step_up_edge%0d bus5=%b rp5=%b want %0d", e, bus_if.io_input_bus[5], bus_if.rise_pending[5], e >= 6);
      end
    end
    bus_if.raw_in[5] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      checks++;
      if (bus_if.io_input_bus[5] !== (e < 6) || bus_if.rise_pending[5] !== 1'b1) begin
        errors++;
        $display("FAIL step_down_edge%0d bus5=%b rp5=%b want %0d/1", e, bus_if.io_input_bus[5], bus_if.rise_pending[5], e < 6);
      end
    end
  endtask

  task automatic test_clear_race();
    bus_if.raw_in[0] = 1'b1;
    for (int e = 0; e < 8; e++) cycle();
    checks++;
    if (bus_if.rise_pending !== 14'h0021) begin
      errors++;
      $display("FAIL race_setup rp=%h want 0021", bus_if.rise_pending);
    end
    bus_if.raw_in[5] = 1'b1;
    for (int e = 0; e < 5; e++) cycle();
    bus_if.clear_valid = 1'b1;
    bus_if.clear_mask  = 14'h0021;
    cycle();
    bus_if.clear_valid = 1'b0;
    checks++;
    if (bus_if.rise_pending !== 14'h0020 || bus_if.io_input_bus[5] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins rp=%h bus5=%b want 0020/1", bus_if.rise_pending, bus_if.io_input_bus[5]);
    end
    bus_if.clear_mask = 14'h3FFF;
    cycle();
    checks++;
    if (bus_if.rise_pending !== 14'h0020) begin
      errors++;
      $display("FAIL race_mask_ignored rp=%h want 0020", bus_if.rise_pending);
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    int rise_at = -1;
    logic prev;
    bus_if.clear_valid = 1'b1;
    bus_if.clear_mask  = 14'h3FFF;
    cycle();
    bus_if.clear_valid = 1'b0;
    bus_if.clear_mask  = '0;
    prev = bus_if.io_input_bus[3];
    for (int t = 0; t < 22; t++) begin
      bus_if.raw_in[3] = (t >= 12) ? 1'b1 : (((t / 2) % 2) == 0);
      cycle();
      if (bus_if.io_input_bus[3] === 1'b1 && prev === 1'b0) begin
        rises++;
        rise_at = t - 11;
      end
      prev = bus_if.io_input_bus[3];
    end
    checks++;
    if (rises !== 1 || rise_at !== 6 || bus_if.rise_pending[3] !== 1'b1) begin
      errors++;
      $display("FAIL bounce rises=%0d at_edge=%0d rp3=%b want 1/6/1", rises, rise_at, bus_if.rise_pending[3]);
    end
  endtask

  task automatic test_reset_mid();
    bus_if.raw_in[7] = 1'b1;
    for (int e = 0; e < 3; e++) cycle();
    reset = 1'b1;
    for (int e = 0; e < 2; e++) begin
      cycle();
      checks++;
      if (bus_if.io_input_bus[7] !== 1'b0 || bus_if.any_pending !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold bus7=%b any=%b want 0/0", bus_if.io_input_bus[7], bus_if.any_pending);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      checks++;
      if (bus_if.io_input_bus[7] !== (e >= 6)) begin
        errors++;
        $display("FAIL midreset_edge%0d bus7=%b want %0d", e, bus_if.io_input_bus[7], e >= 6);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) bus_if.raw_in[i] = ~bus_if.raw_in[i];
      bus_if.clear_valid = ($urandom_range(3) == 0);
      bus_if.clear_mask  = W'($urandom);
      cycle();
      checks++;
      if (bus_if.io_input_bus !== m_stable || bus_if.rise_pending !== m_rp ||
          bus_if.any_pending !== (|m_rp)) begin
        errors++;
        $display("FAIL random_c%0d bus=%h rp=%h any=%b want %h/%h/%b", c, bus_if.io_input_bus,
                 bus_if.rise_pending, bus_if.any_pending, m_stable, m_rp, |m_rp);
      end
    end
    bus_if.clear_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_step();
    test_clear_race();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
